lif_neuron_array: RTL



---
 rtl/lif_neuron_array.sv | 77 +++++++
 1 files changed

// File: rtl/lif_neuron_array.sv
// N-channel leaky integrate-and-fire neuron array with a shift-based leak,
// a shared threshold, per-channel refractory counters and a global spike counter.
module lif_neuron_array #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned RW = 3,
  parameter int unsigned CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
  input  logic [N*W-1:0]  current,
  input  logic [W-1:0]    threshold,
  input  logic [3:0]      leak_shift,
  input  logic [RW-1:0]   refrac_len,
  output logic [N-1:0]    spike,
  output logic [N*W-1:0]  membrane,
  output logic [CW-1:0]   spike_count
);

  logic [N*W-1:0] mem_q, mem_d;
  logic [RW-1:0]  rc_q [N];
  logic [RW-1:0]  rc_d [N];
  logic [N-1:0]   spike_q, spike_d;
  logic [CW-1:0]  count_q, count_d;

  logic [W-1:0]   u     [N];
  logic [W-1:0]   decay [N];
  logic [W-1:0]   sat   [N];
  logic [W:0]     sum   [N];

  always_comb begin
    mem_d   = mem_q;
    spike_d = '0;
    count_d = count_q;
    for (int i = 0; i < N; i++) begin
      rc_d[i]  = rc_q[i];
      u[i]     = mem_q[i*W +: W];
      // A shift of W or more yields zero, so the leak term vanishes naturally.
      decay[i] = (leak_shift == 4'd0) ? u[i] : u[i] - (u[i] >> leak_shift);
      sum[i]   = {1'b0, decay[i]} + {1'b0, current[i*W +: W]};
      sat[i]   = sum[i][W] ? {W{1'b1}} : sum[i][W-1:0];
      if (step) begin
        if (rc_q[i] != '0) begin
          rc_d[i]          = rc_q[i] - RW'(1);
          mem_d[i*W +: W]  = '0;
        end else if (sat[i] >= threshold) begin
          spike_d[i]       = 1'b1;
          mem_d[i*W +: W]  = '0;
          rc_d[i]          = refrac_len;
        end else begin
          mem_d[i*W +: W]  = sat[i];
        end
      end
      count_d = count_d + CW'(spike_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      spike_q <= '0;
      count_q <= '0;
      for (int i = 0; i < N; i++) rc_q[i] <= '0;
    end else begin
      mem_q   <= mem_d;
      spike_q <= spike_d;
      count_q <= count_d;
      for (int i = 0; i < N; i++) rc_q[i] <= rc_d[i];
    end
  end

  assign spike       = spike_q;
  assign membrane    = mem_q;
  assign spike_count = count_q;

endmodule
